// File: rtl/key_input_pio.sv
// key_input_pio: memory-mapped input port. Synchronises and debounces board
// key/switch lines, latches edges that leave the idle level, and presents
// data / irqmask / edgecapture / raw registers over a 32-bit Avalon-MM slave.
// The level interrupt is high while any captured edge is masked in.
module key_input_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int IDLE_LEVEL      = 1
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   input  logic [WIDTH-1:0] keys_export,
   output logic             irq
);

   localparam int                CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [WIDTH-1:0]  IDLE_VEC = {WIDTH{(IDLE_LEVEL != 0)}};
   localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP = 2'd2;
   localparam logic [1:0] ADDR_RAW     = 2'd3;

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] debounced_reg;
   logic [WIDTH-1:0] debounced_next;
   logic [CW-1:0]    count_reg  [WIDTH];
   logic [CW-1:0]    count_next [WIDTH];

   logic [WIDTH-1:0] irqmask_reg;
   logic [WIDTH-1:0] edgecapture_reg;
   logic [WIDTH-1:0] edgecapture_next;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] edge_clr;
   logic [31:0]      readdata_reg;
   logic [31:0]      readdata_next;

   // Only the low WIDTH bits of a write carry register contents.
   logic unused_wdata;
   assign unused_wdata = ^avs_writedata;

   // Per-bit debounce: a bit only changes after DEBOUNCE_CYCLES consecutive
   // samples that disagree with it; any agreeing sample restarts the count.
   // An edge is flagged on the same cycle the debounced bit leaves idle.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign count_next[gi] =
            ((sync2_reg[gi] == debounced_reg[gi]) || (count_reg[gi] == CNT_LAST))
               ? '0 : count_reg[gi] + CW'(1);
         assign debounced_next[gi] =
            ((sync2_reg[gi] != debounced_reg[gi]) && (count_reg[gi] == CNT_LAST))
               ? sync2_reg[gi] : debounced_reg[gi];
         assign edge_set[gi] = (debounced_reg[gi] == IDLE_VEC[gi]) &&
                               (debounced_next[gi] != IDLE_VEC[gi]);
      end
   endgenerate

   // Write-1-to-clear on edgecapture; a new edge in the same cycle wins.
   assign edge_clr = (avs_write && (avs_address == ADDR_EDGECAP))
                     ? avs_writedata[WIDTH-1:0] : '0;
   assign edgecapture_next = (edgecapture_reg & ~edge_clr) | edge_set;

   // Read mux over pre-write register values, zero-extended to the bus.
   always_comb begin
      readdata_next = readdata_reg;
      if (avs_read) begin
         unique case (avs_address)
            ADDR_DATA:    readdata_next = 32'(debounced_reg);
            ADDR_IRQMASK: readdata_next = 32'(irqmask_reg);
            ADDR_EDGECAP: readdata_next = 32'(edgecapture_reg);
            ADDR_RAW:     readdata_next = 32'(sync2_reg);
            default:      readdata_next = '0;
         endcase
      end
   end

   // Input synchroniser and debounce state.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         sync1_reg     <= IDLE_VEC;
         sync2_reg     <= IDLE_VEC;
         debounced_reg <= IDLE_VEC;
         for (int i = 0; i < WIDTH; i++) begin
            count_reg[i] <= '0;
         end
      end else begin
         sync1_reg     <= keys_export;
         sync2_reg     <= sync1_reg;
         debounced_reg <= debounced_next;
         for (int i = 0; i < WIDTH; i++) begin
            count_reg[i] <= count_next[i];
         end
      end
   end

   // Bus-visible registers: irqmask, edgecapture and the registered read data.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         irqmask_reg     <= '0;
         edgecapture_reg <= '0;
         readdata_reg    <= '0;
      end else begin
         if (avs_write && (avs_address == ADDR_IRQMASK)) begin
            irqmask_reg <= avs_writedata[WIDTH-1:0];
         end
         edgecapture_reg <= edgecapture_next;
         readdata_reg    <= readdata_next;
      end
   end

   assign avs_readdata = readdata_reg;
   assign irq          = |(edgecapture_reg & irqmask_reg);

endmodule

// File: doc/key_input_pio.md
# key_input_pio

Memory-mapped input port for the HPS design: the inbound counterpart of the LED output PIO. It samples asynchronous push-button/switch lines from the board and synchronises and debounces them. It latches edges away from the idle level and presents data, edge-capture and interrupt-mask registers to the HPS over a 32-bit Avalon-MM slave, raising a level interrupt on any enabled captured edge.

## Interface

Parameters:
- WIDTH, 4, number of input lines (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced bit changes (≥2; 1 ms at 50 MHz)
- IDLE_LEVEL, 1, released level of every line (1 = active-low keys); an edge is captured when a debounced bit leaves this level

Ports:
- clk_clk  in  1  system clock; every register is clocked on its rising edge
- reset_reset  in  1  asynchronous, active-high reset
- avs_address  in  2  word address: 0 data, 1 irqmask, 2 edgecapture, 3 raw
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered, fixed latency 1
- keys_export  in  WIDTH  asynchronous board inputs
- irq  out  1  level interrupt, high while (edgecapture & irqmask) != 0

## Operation

- Synchroniser: two flops per bit, sync1 then sync2. Reset value is IDLE_LEVEL on all bits.
- Debounce: one counter per bit, width clog2(DEBOUNCE_CYCLES+1).
  - When sync2 == debounced, the counter clears to 0.
  - Otherwise the counter increments.
  - When sync2 != debounced and the counter == DEBOUNCE_CYCLES-1, debounced takes sync2 and the counter clears.
  - Any return of sync2 to the debounced value before that point clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Edge capture: edgecapture[i] sets on the edge where debounced[i] changes from IDLE_LEVEL to !IDLE_LEVEL. The return edge is not captured.
- Register map (bits ≥ WIDTH read 0 and ignore writes):
  - 0 data: RO, debounced value. Writes ignored.
  - 1 irqmask: RW, reset 0.
  - 2 edgecapture: write-1-to-clear, reset 0. Reads return current bits.
  - 3 raw: RO, sync2. Writes ignored.
- Simultaneous set and clear of the same edgecapture bit in one cycle: set wins, bit stays 1.
- irq is combinational from the edgecapture and irqmask registers, so it needs no extra cycle. Clearing the last enabled bit or its mask deasserts irq on the edge after the write.
- Read and write in the same cycle are both honoured. The read returns the pre-write value.
- avs_readdata updates only on cycles with avs_read high and otherwise holds its value.

## Timing

- Reset (asynchronous assert, released synchronously by the system reset controller):
  - avs_readdata = 0
  - irq = 0
  - irqmask = 0
  - edgecapture = 0
  - counters = 0
  - sync1, sync2 and debounced = IDLE_LEVEL
- Reset asserted mid-debounce or with a pending edge discards all state. No edge is captured on reset release.
- Read latency: avs_readdata is valid on the rising edge after the cycle where avs_read is sampled high. There is no waitrequest.
- Pin-to-debounced latency for a clean change applied before edge 0:
  - sync2 reflects the change after edge 1.
  - debounced and edgecapture change at edge DEBOUNCE_CYCLES+1.
  - irq rises in that same cycle if the bit is masked in.
- Writes take effect on the rising edge on which avs_write is sampled.

## Test plan

All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1.

- Reset: hold keys_export=4'hF and pulse reset_reset mid-cycle -> readdata 0 and irq 0 immediately. Reading addresses 0/1/2/3 after release returns 0xF/0x0/0x0/0xF.
- Clean press: drive bit 2 low and set irqmask=0x4 -> data reads 0xB and edgecapture reads 0x4 exactly 5 edges after the change. irq rises on that same edge. Writing 0x4 to address 2 drops irq the next cycle.
- Glitch rejection: drive bit 0 low for 3 cycles, then high -> data stays 0xF, edgecapture stays 0, irq stays 0. Raw shows 0xE transiently.
- Release not captured: press then release bit 1, each held for 10 cycles, with irqmask=0 -> edgecapture=0x2 only, irq=0 throughout. Writing irqmask=0x2 asserts irq the next cycle.
- Set/clear collision: time a write of 0x8 to address 2 on the same edge bit 3's press is captured -> edgecapture bit 3 reads 1.
- Reset mid-debounce: drive bit 0 low and assert reset after 2 stable cycles, with the pin still low at release -> no edge is captured at reset. data bit 0 goes low 5 edges after release, and edgecapture bit 0 then sets.
